// File: rtl/mlab_fifo_ctrl.sv
// Show-ahead FIFO controller sequencing an MLAB RAM (registered write, asynchronous read)
// with a registered output stage and valid/ready handshakes on both sides.
module mlab_fifo_ctrl #(
   parameter int WIDTH      = 20,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  sclr,
   input  logic [WIDTH-1:0]      din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [WIDTH-1:0]      dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [ADDR_WIDTH:0]   used_words,
   output logic                  ram_wena,
   output logic [ADDR_WIDTH-1:0] ram_waddr,
   output logic [WIDTH-1:0]      ram_wdata,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   input  logic [WIDTH-1:0]      ram_rdata
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] commit_ptr_q, commit_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
   logic [ADDR_WIDTH:0]   used_q, used_d;
   logic                  dout_valid_q, dout_valid_d;
   logic                  din_ready_q, din_ready_d;
   logic [WIDTH-1:0]      dout_q, dout_d;
   logic                  wena_q, wena_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [WIDTH-1:0]      wdata_q, wdata_d;

   logic push, pop, canLoad, load;

   assign push = din_valid & din_ready_q & ~sclr;
   assign pop  = dout_valid_q & dout_ready & ~sclr;

   // Equal pointers mean either nothing committed or a full wrap committed with no write pending.
   assign canLoad = (rd_ptr_q != commit_ptr_q) | ((ram_count_q == DEPTH_C) & ~wena_q);
   assign load    = canLoad & (~dout_valid_q | pop) & ~sclr;

   always_comb begin
      wr_ptr_d     = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      commit_ptr_d = wena_q ? commit_ptr_q + PTR_ONE : commit_ptr_q;
      rd_ptr_d     = load ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      wena_d       = push;
      waddr_d      = push ? wr_ptr_q : waddr_q;
      wdata_d      = push ? din : wdata_q;
      dout_d       = load ? ram_rdata : dout_q;
      dout_valid_d = load ? 1'b1 : (pop ? 1'b0 : dout_valid_q);
      case ({push, load})
         2'b10:   ram_count_d = ram_count_q + CNT_ONE;
         2'b01:   ram_count_d = ram_count_q - CNT_ONE;
         default: ram_count_d = ram_count_q;
      endcase
      if (sclr) begin
         wr_ptr_d     = '0;
         commit_ptr_d = '0;
         rd_ptr_d     = '0;
         ram_count_d  = '0;
         dout_valid_d = 1'b0;
      end
      din_ready_d = (ram_count_d < DEPTH_C);
      used_d      = ram_count_d + {{ADDR_WIDTH{1'b0}}, dout_valid_d};
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         ram_count_q  <= '0;
         used_q       <= '0;
         dout_valid_q <= 1'b0;
         din_ready_q  <= 1'b0;
         dout_q       <= '0;
         wena_q       <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         ram_count_q  <= ram_count_d;
         used_q       <= used_d;
         dout_valid_q <= dout_valid_d;
         din_ready_q  <= din_ready_d;
         dout_q       <= dout_d;
         wena_q       <= wena_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
      end
   end

   assign din_ready  = din_ready_q;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign used_words = used_q;
   assign ram_wena   = wena_q;
   assign ram_waddr  = waddr_q;
   assign ram_wdata  = wdata_q;
   assign ram_raddr  = rd_ptr_q;

endmodule

// File: tb/tb_mlab_fifo_ctrl.sv
// Scoreboard bench for mlab_fifo_ctrl with a behavioural MLAB RAM beside the controller.
module tb_mlab_fifo_ctrl;

   localparam int WIDTH      = 20;
   localparam int ADDR_WIDTH = 5;
   localparam int DEPTH      = 1 << ADDR_WIDTH;

   logic                  clk = 1'b0;
   logic                  arst, sclr, din_valid, din_ready, dout_valid, dout_ready, ram_wena;
   logic [WIDTH-1:0]      din, dout, ram_wdata, ram_rdata;
   logic [ADDR_WIDTH:0]   used_words;
   logic [ADDR_WIDTH-1:0] ram_waddr, ram_raddr;
   logic [WIDTH-1:0]      mem [DEPTH];

   int              checks = 0;
   int              failures = 0;
   int              popCount = 0;
   int              pushCount = 0;
   bit              lastPush;
   logic [WIDTH-1:0] lastDout;
   logic [WIDTH-1:0] sbQ [$];

   mlab_fifo_ctrl #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk(clk), .arst(arst), .sclr(sclr),
      .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .used_words(used_words),
      .ram_wena(ram_wena), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: registered write, asynchronous read.
   always @(posedge clk) if (ram_wena) mem[ram_waddr] <= ram_wdata;
   assign ram_rdata = mem[ram_raddr];

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, score the transfers the next
   // rising edge performs, then check the post-edge state against the model.
   task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic c);
      bit doPush, doPop;
      din_valid  = v;
      din        = d;
      dout_ready = r;
      sclr       = c;
      doPush = v & din_ready & ~c;
      doPop  = dout_valid & r & ~c;
      lastPush = doPush;
      if (doPop) begin
         popCount++;
         if (sbQ.size() == 0) checkOutput("sb_underflow", sbQ.size(), 1);
         else checkOutput("data", dout, sbQ.pop_front());
      end
      if (doPush) begin
         pushCount++;
         sbQ.push_back(d);
      end
      if (c) sbQ.delete();
      @(posedge clk);
      @(negedge clk);
      checkOutput("used", used_words, sbQ.size());
      if (sbQ.size() < DEPTH) checkOutput("rdy_space", din_ready, 1);
      if (sbQ.size() == DEPTH + 1) checkOutput("rdy_full", din_ready, 0);
      if (dout_valid) lastDout = dout;
      else checkOutput("dout_hold", dout, lastDout);
      if (ram_wena && ram_waddr == ram_raddr)
         checkOutput("addr_overlap", used_words - dout_valid, 1);
   endtask

   // Asserts arst, checks reset values immediately, then the first edge after release.
   task automatic resetAndCheck(input string tag);
      din_valid = 0; din = '0; dout_ready = 0; sclr = 0;
      arst = 1'b1;
      #1;
      checkOutput({tag, "_rst_ready"}, din_ready, 0);
      checkOutput({tag, "_rst_dvalid"}, dout_valid, 0);
      checkOutput({tag, "_rst_dout"}, dout, 0);
      checkOutput({tag, "_rst_used"}, used_words, 0);
      checkOutput({tag, "_rst_wena"}, ram_wena, 0);
      checkOutput({tag, "_rst_waddr"}, ram_waddr, 0);
      checkOutput({tag, "_rst_wdata"}, ram_wdata, 0);
      checkOutput({tag, "_rst_raddr"}, ram_raddr, 0);
      sbQ.delete();
      lastDout = '0;
      @(posedge clk);
      @(negedge clk);
      arst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput({tag, "_rel_ready"}, din_ready, 1);
      checkOutput({tag, "_rel_used"}, used_words, 0);
      @(negedge clk);
   endtask

   initial begin
      int accepted;
      int pv, pr;
      resetAndCheck("init");

      // Latency of a single word through RAM and output stage.
      applyStimulus(1, WIDTH'('hABCDE), 0, 0);
      checkOutput("lat_e0_valid", dout_valid, 0);
      applyStimulus(0, '0, 0, 0);
      checkOutput("lat_e1_valid", dout_valid, 0);
      applyStimulus(0, '0, 0, 0);
      checkOutput("lat_e2_valid", dout_valid, 1);
      checkOutput("lat_e2_dout", dout, 'hABCDE);
      checkOutput("lat_e2_used", used_words, 1);
      applyStimulus(0, '0, 1, 0);
      checkOutput("lat_pop_valid", dout_valid, 0);

      // Fill to capacity, then drain one word per cycle.
      accepted = 0;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1, WIDTH'(i), 0, 0);
         if (lastPush) accepted++;
      end
      checkOutput("fill_accepted", accepted, 33);
      checkOutput("fill_ready", din_ready, 0);
      checkOutput("fill_used", used_words, 33);
      popCount = 0;
      for (int i = 0; i < 33; i++) applyStimulus(0, '0, 1, 0);
      checkOutput("drain_count", popCount, 33);
      checkOutput("drain_used", used_words, 0);

      // Full-throughput streaming across several pointer wraps.
      popCount = 0;
      pushCount = 0;
      for (int i = 0; i < 100; i++) begin
         checkOutput("stream_ready", din_ready, 1);
         applyStimulus(1, WIDTH'(1000 + i), 1, 0);
      end
      for (int i = 0; i < 5; i++) applyStimulus(0, '0, 1, 0);
      checkOutput("stream_pushes", pushCount, 100);
      checkOutput("stream_pops", popCount, 100);

      // Random traffic with varying push and pop rates.
      for (int blk = 0; blk < 10; blk++) begin
         pv = $urandom_range(20, 95);
         pr = $urandom_range(20, 95);
         for (int i = 0; i < 1000; i++)
            applyStimulus($urandom_range(0, 99) < pv, WIDTH'($urandom), $urandom_range(0, 99) < pr, 0);
      end
      for (int i = 0; i < 60; i++) applyStimulus(0, '0, 1, 0);
      checkOutput("rand_empty", used_words, 0);

      // Flush with a write in flight and a push and pop presented alongside sclr.
      for (int i = 0; i < 10; i++) applyStimulus(1, WIDTH'('h500 + i), 0, 0);
      applyStimulus(1, WIDTH'('h777), 1, 1);
      checkOutput("flush_used", used_words, 0);
      checkOutput("flush_dvalid", dout_valid, 0);
      checkOutput("flush_ready", din_ready, 1);
      applyStimulus(1, WIDTH'('h12345), 0, 0);
      applyStimulus(0, '0, 0, 0);
      applyStimulus(0, '0, 0, 0);
      checkOutput("flush_next", dout, 'h12345);
      popCount = 0;
      applyStimulus(0, '0, 1, 0);
      checkOutput("flush_popped", popCount, 1);

      // Asynchronous reset in the middle of traffic.
      for (int i = 0; i < 5; i++) applyStimulus(1, WIDTH'('h900 + i), 0, 0);
      resetAndCheck("mid");
      applyStimulus(1, WIDTH'('h4242), 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, '0, 1, 0);
      checkOutput("post_rst_used", used_words, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
